// File: rtl/axi_lite_reg_interface.sv
// Purpose : single-outstanding AXI4-Lite slave bridging AXI reads/writes onto a one-cycle register strobe.
// Latency : read AR@N -> R valid @N+1; write AW@N -> W accepted @N+1 at the earliest -> B valid @N+2.
// Backpres: one transaction in flight; AR/AW are refused until R/B handshakes, and W is refused until AW is taken.
//
// Ports:
//   clk_i, rst_i (sync, active-high)
//   aw_*/w_*/b_*  write address / data / response channels (w_strb_i ignored, full-word writes)
//   ar_*/r_*      read address / data channels (single beat, r_last_o always 1)
//   address_o, en_o, we_o, data_o, data_i   register-file port (data_i combinational on address_o/en_o)
// Optional: define AXI_LITE_ALIGN_CHECK_EN to answer misaligned accesses with SLVERR and no strobe.
module axi_lite_reg_interface #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        aw_valid_i,
    output logic                        aw_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
    input  logic                        w_valid_i,
    output logic                        w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
    output logic                        b_valid_o,
    input  logic                        b_ready_i,
    output logic [AXI_ID_WIDTH-1:0]     b_id_o,
    output logic [1:0]                  b_resp_o,
    input  logic                        ar_valid_i,
    output logic                        ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
    output logic                        r_valid_o,
    input  logic                        r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
    output logic [AXI_ID_WIDTH-1:0]     r_id_o,
    output logic [1:0]                  r_resp_o,
    output logic                        r_last_o,
    output logic [AXI_ADDR_WIDTH-1:0]   address_o,
    output logic                        en_o,
    output logic                        we_o,
    input  logic [AXI_DATA_WIDTH-1:0]   data_i,
    output logic [AXI_DATA_WIDTH-1:0]   data_o
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, WRITE_B} state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_e                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_ID_WIDTH-1:0]   id_q, id_d;
    logic                      misaligned;

    // Byte strobes carry no information here: every write is a full word.
    logic unused_strb;
    assign unused_strb = ^w_strb_i;

`ifdef AXI_LITE_ALIGN_CHECK_EN
    localparam int unsigned OFF_W = $clog2(AXI_DATA_WIDTH / 8);
    assign misaligned = |addr_q[OFF_W-1:0];
`else
    assign misaligned = 1'b0;
`endif

    assign address_o = addr_q;
    assign b_id_o    = id_q;
    assign r_id_o    = id_q;
    assign r_last_o  = 1'b1;
    assign data_o    = w_data_i;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        id_d       = id_q;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        b_resp_o   = RESP_OKAY;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        r_data_o   = '0;
        r_resp_o   = RESP_OKAY;
        en_o       = 1'b0;
        we_o       = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Reads take priority; a concurrent AW simply waits here.
                if (ar_valid_i) begin
                    ar_ready_o = 1'b1;
                    addr_d     = ar_addr_i;
                    id_d       = ar_id_i;
                    state_d    = READ;
                end else if (aw_valid_i) begin
                    aw_ready_o = 1'b1;
                    addr_d     = aw_addr_i;
                    id_d       = aw_id_i;
                    state_d    = WRITE;
                end
            end
            READ: begin
                // The strobe is held for the whole R stall so data_i stays valid.
                r_valid_o = 1'b1;
                if (misaligned) begin
                    r_resp_o = RESP_SLVERR;
                end else begin
                    en_o     = 1'b1;
                    r_data_o = data_i;
                end
                if (r_ready_i) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                w_ready_o = 1'b1;
                if (w_valid_i) begin
                    en_o    = !misaligned;
                    we_o    = !misaligned;
                    state_d = WRITE_B;
                end
            end
            WRITE_B: begin
                b_valid_o = 1'b1;
                b_resp_o  = misaligned ? RESP_SLVERR : RESP_OKAY;
                if (b_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_interface.sv
module tb_axi_lite_reg_interface;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          aw_valid, aw_ready;
    logic [AW-1:0] aw_addr;
    logic [IW-1:0] aw_id;
    logic          w_valid, w_ready;
    logic [DW-1:0] w_data;
    logic [DW/8-1:0] w_strb;
    logic          b_valid, b_ready;
    logic [IW-1:0] b_id;
    logic [1:0]    b_resp;
    logic          ar_valid, ar_ready;
    logic [AW-1:0] ar_addr;
    logic [IW-1:0] ar_id;
    logic          r_valid, r_ready;
    logic [DW-1:0] r_data;
    logic [IW-1:0] r_id;
    logic [1:0]    r_resp;
    logic          r_last;
    logic [AW-1:0] address;
    logic          en, we;
    logic [DW-1:0] data_in, data_out;
    logic [DW-1:0] rd_word;

    // Register-file model: returns the word the current vector expects, only while strobed.
    assign data_in = en ? rd_word : '0;

    axi_lite_reg_interface #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_addr_i(aw_addr), .aw_id_i(aw_id),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data), .w_strb_i(w_strb),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id), .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_addr_i(ar_addr), .ar_id_i(ar_id),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data), .r_id_o(r_id),
        .r_resp_o(r_resp), .r_last_o(r_last),
        .address_o(address), .en_o(en), .we_o(we), .data_i(data_in), .data_o(data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        int            stall;   // cycles with r_ready/b_ready low
        int            w_delay; // cycles before w_valid rises
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[6];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output exp_t e, output bit ok);
        ok = (exp_q.size() != 0);
        n_total++;
        if (ok) begin
            n_pass++;
            e = exp_q.pop_front();
        end else begin
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            e = '{addr: '0, id: '0, data: '0};
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                           input logic [DW-1:0] data, input int stall);
        exp_t e;
        bit   ok;
        ar_valid = 1'b1; ar_addr = addr; ar_id = id; rd_word = data;
        @(negedge clk);
        check("ar_ready_pulse", ar_ready, 1'b1);
        exp_q.push_back('{addr: addr, id: id, data: data});
        next_cycle();
        ar_valid = 1'b0; r_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            aw_valid = 1'b1; // must not be taken while a read is outstanding
            @(negedge clk);
            check("r_valid_held", r_valid, 1'b1);
            check("r_data_stable", r_data, data);
            check("en_held", {we, en}, 2'b01);
            check("aw_blocked_rd", aw_ready, 1'b0);
            next_cycle();
        end
        aw_valid = 1'b0;
        r_ready = 1'b1;
        @(negedge clk);
        check("r_valid", r_valid, 1'b1);
        pop_exp(e, ok);
        check("r_data", r_data, e.data);
        check("r_id", r_id, e.id);
        check("r_resp_last", {r_resp, r_last}, 3'b001);
        check("rd_address", address, e.addr);
        check("rd_en_we", {we, en}, 2'b01);
        next_cycle();
        r_ready = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [IW-1:0] id,
                            input logic [DW-1:0] data, input int w_delay, input int stall);
        exp_t e;
        bit   ok;
        aw_valid = 1'b1; aw_addr = addr; aw_id = id;
        @(negedge clk);
        check("aw_ready_pulse", aw_ready, 1'b1);
        exp_q.push_back('{addr: addr, id: id, data: data});
        next_cycle();
        aw_valid = 1'b0;
        for (int i = 0; i < w_delay; i++) begin
            @(negedge clk);
            check("w_ready_wait", w_ready, 1'b1);
            check("en_idle_wait", {we, en}, 2'b00);
            next_cycle();
        end
        w_valid = 1'b1; w_data = data;
        @(negedge clk);
        check("wr_strobe", {we, en, w_ready}, 3'b111);
        check("wr_address", address, exp_q[0].addr);
        check("wr_data_o", data_out, exp_q[0].data);
        next_cycle();
        w_valid = 1'b0; w_data = '0; b_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            ar_valid = 1'b1;
            @(negedge clk);
            check("b_valid_held", b_valid, 1'b1);
            check("ar_blocked_wr", ar_ready, 1'b0);
            check("en_after_wr", en, 1'b0);
            next_cycle();
        end
        ar_valid = 1'b0;
        b_ready = 1'b1;
        @(negedge clk);
        check("b_valid", b_valid, 1'b1);
        pop_exp(e, ok);
        check("b_id", b_id, e.id);
        check("b_resp", b_resp, 2'b00);
        next_cycle();
        b_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        bit   ok;
        vecs[0] = '{is_wr: 0, addr: 64'hBFF8, id: 10'h3, data: 64'h1234, stall: 0, w_delay: 0};
        vecs[1] = '{is_wr: 1, addr: 64'h4000, id: 10'h5, data: 64'hDEADBEEF, stall: 0, w_delay: 0};
        vecs[2] = '{is_wr: 0, addr: 64'h8, id: 10'h3FF, data: 64'hFFFF_FFFF_FFFF_FFFF, stall: 5, w_delay: 0};
        vecs[3] = '{is_wr: 1, addr: 64'hFFFF_FFFF_FFFF_FFF8, id: 10'h200, data: 64'h0123_4567_89AB_CDEF, stall: 3, w_delay: 4};
        vecs[4] = '{is_wr: 0, addr: 64'h0, id: 10'h0, data: 64'h0, stall: 1, w_delay: 0};
        vecs[5] = '{is_wr: 1, addr: 64'h10, id: 10'h1, data: 64'h0, stall: 1, w_delay: 1};

        rst = 1'b1;
        aw_valid = 0; aw_addr = '0; aw_id = '0;
        w_valid = 0; w_data = '0; w_strb = '1;
        b_ready = 0; ar_valid = 0; ar_addr = '0; ar_id = '0; r_ready = 0;
        rd_word = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_valids", {r_valid, b_valid, ar_ready, aw_ready, w_ready}, 5'b0);
        check("rst_strobe", {we, en}, 2'b00);
        check("rst_address", address, 64'h0);
        check("rst_ids", {r_id, b_id}, 20'h0);
        check("rst_last_resp", {r_last, r_resp, b_resp}, 5'b10000);
        next_cycle();
        rst = 1'b0;

        // W ahead of AW must be refused in IDLE.
        w_valid = 1'b1; w_data = 64'hBAD;
        @(negedge clk);
        check("early_w_refused", {w_ready, en, we}, 3'b000);
        next_cycle();
        w_valid = 1'b0; w_data = '0;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_wr)
                do_write(vecs[i].addr, vecs[i].id, vecs[i].data, vecs[i].w_delay, vecs[i].stall);
            else
                do_read(vecs[i].addr, vecs[i].id, vecs[i].data, vecs[i].stall);
        end

        // Concurrent AR and AW: the read wins and the write follows.
        ar_valid = 1'b1; ar_addr = 64'h20; ar_id = 10'h7; rd_word = 64'hCAFE;
        aw_valid = 1'b1; aw_addr = 64'h28; aw_id = 10'h9;
        @(negedge clk);
        check("both_ar_first", {ar_ready, aw_ready}, 2'b10);
        exp_q.push_back('{addr: 64'h20, id: 10'h7, data: 64'hCAFE});
        next_cycle();
        ar_valid = 1'b0; r_ready = 1'b1;
        @(negedge clk);
        check("both_aw_waits", aw_ready, 1'b0);
        pop_exp(e, ok);
        check("both_r_data", r_data, e.data);
        check("both_r_id", r_id, e.id);
        next_cycle();
        r_ready = 1'b0;
        do_write(64'h28, 10'h9, 64'h5555_AAAA, 0, 0);

        // Reset in the middle of a read abandons it.
        ar_valid = 1'b1; ar_addr = 64'h30; ar_id = 10'h11; rd_word = 64'h77;
        @(negedge clk);
        check("abort_ar_ready", ar_ready, 1'b1);
        next_cycle();
        ar_valid = 1'b0;
        @(negedge clk);
        check("abort_in_read", {r_valid, en}, 2'b11);
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("abort_idle", {r_valid, en, b_valid}, 3'b000);
        check("abort_address", address, 64'h0);
        check("abort_id", r_id, 10'h0);
        next_cycle();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
